// File: rtl/ac_exec_pkg.sv
// Shared definitions for the accumulator execute stage: command codes, ALU
// operation codes, FSM state encoding and flag bit positions.
package ac_exec_pkg;

  localparam logic [3:0] CMD_ADD = 4'd0;
  localparam logic [3:0] CMD_AND = 4'd1;
  localparam logic [3:0] CMD_LDA = 4'd2;
  localparam logic [3:0] CMD_CMA = 4'd3;
  localparam logic [3:0] CMD_CIR = 4'd4;
  localparam logic [3:0] CMD_CIL = 4'd5;
  localparam logic [3:0] CMD_INC = 4'd6;
  localparam logic [3:0] CMD_CLA = 4'd7;
  localparam logic [3:0] CMD_CLE = 4'd8;
  localparam logic [3:0] CMD_CME = 4'd9;

  localparam logic [2:0] ALU_ADD  = 3'd0;
  localparam logic [2:0] ALU_AND  = 3'd1;
  localparam logic [2:0] ALU_PASS = 3'd2;
  localparam logic [2:0] ALU_CMA  = 3'd3;
  localparam logic [2:0] ALU_SHR  = 3'd4;
  localparam logic [2:0] ALU_SHL  = 3'd5;

  localparam int FLAG_CO  = 3;
  localparam int FLAG_OVF = 2;
  localparam int FLAG_N   = 1;
  localparam int FLAG_Z   = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic [2:0] alu_op_of(input logic [3:0] op);
    case (op)
      CMD_AND: return ALU_AND;
      CMD_LDA: return ALU_PASS;
      CMD_CMA: return ALU_CMA;
      CMD_CIR: return ALU_SHR;
      CMD_CIL: return ALU_SHL;
      default: return ALU_ADD;
    endcase
  endfunction

  function automatic logic is_alu_cmd(input logic [3:0] op);
    return op <= CMD_INC;
  endfunction

  function automatic logic is_reserved(input logic [3:0] op);
    return op > CMD_CME;
  endfunction

endpackage

// File: rtl/ac_flag_reg.sv
// {CO,OVF,N,Z} flag register. Build option OVF_STICKY_EN makes OVF accumulate
// across ALU ops until CLA or reset; otherwise OVF follows each ALU op.
module ac_flag_reg
  import ac_exec_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       alu_wr_i,
  input  logic       cla_i,
  input  logic       co_i,
  input  logic       ovf_i,
  input  logic       n_i,
  input  logic       z_i,
  output logic [3:0] flags_o
);

  logic [3:0] flags_q, flags_d;
  logic       ovf_next;

`ifdef OVF_STICKY_EN
  assign ovf_next = flags_q[FLAG_OVF] | ovf_i;
`else
  assign ovf_next = ovf_i;
`endif

  // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    flags_d = flags_q;
    if (cla_i) begin
      flags_d        = '0;
      flags_d[FLAG_Z] = 1'b1;
    end else if (alu_wr_i) begin
      flags_d[FLAG_CO]  = co_i;
      flags_d[FLAG_OVF] = ovf_next;
      flags_d[FLAG_N]   = n_i;
      flags_d[FLAG_Z]   = z_i;
    end
  end

  // NOTE: state registers use non-blocking assignment so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) flags_q <= '0;
    else        flags_q <= flags_d;
  end

  assign flags_o = flags_q;

endmodule

// File: rtl/ac_exec_unit.sv
// Accumulator execute stage: accepts a command, drives the external ALU for one
// cycle from registered operands, then retires results into AC/E/flags.
module ac_exec_unit
  import ac_exec_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [3:0]   cmd_op,
  input  logic [W-1:0] cmd_data,
  output logic [W-1:0] alu_ac,
  output logic [W-1:0] alu_dr,
  output logic         alu_e,
  output logic [2:0]   alu_op,
  input  logic [W-1:0] alu_res,
  input  logic         alu_co,
  input  logic         alu_ovf,
  input  logic         alu_n,
  input  logic         alu_z,
  output logic [W-1:0] ac,
  output logic         e,
  output logic [3:0]   flags,
  output logic         done,
  output logic         cmd_err
);

  state_e       state_q, state_d;
  logic [3:0]   op_q, op_d;
  logic [W-1:0] ac_q, ac_d, dr_q, dr_d;
  logic         e_q, e_d;
  logic [2:0]   alu_op_q, alu_op_d;
  logic         alu_e_q, alu_e_d;
  logic         accept, exec, flag_alu_wr, flag_cla;

  assign accept = cmd_valid && cmd_ready;
  assign exec   = (state_q == ST_EXEC);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = ST_EXEC;
      ST_EXEC: state_d = ST_DONE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = (state_q == ST_IDLE);
    done      = (state_q == ST_DONE);
    cmd_err   = (state_q == ST_DONE) && is_reserved(op_q);
  end

  // ALU operands are loaded on accept and held, so they stay stable through EXEC.
  always_comb begin
    op_d        = op_q;
    dr_d        = dr_q;
    alu_op_d    = alu_op_q;
    alu_e_d     = alu_e_q;
    ac_d        = ac_q;
    e_d         = e_q;
    flag_alu_wr = 1'b0;
    flag_cla    = 1'b0;
    if (accept) begin
      op_d     = cmd_op;
      dr_d     = (cmd_op == CMD_INC) ? W'(1) : cmd_data;
      alu_op_d = alu_op_of(cmd_op);
      alu_e_d  = (cmd_op == CMD_CIR) || (cmd_op == CMD_CIL);
    end
    if (exec) begin
      if (is_alu_cmd(op_q)) begin
        ac_d        = alu_res;
        flag_alu_wr = 1'b1;
        if (op_q == CMD_ADD || op_q == CMD_INC || op_q == CMD_CIR || op_q == CMD_CIL)
          e_d = alu_co;
      end else begin
        case (op_q)
          CMD_CLA: begin
            ac_d     = '0;
            flag_cla = 1'b1;
          end
          CMD_CLE: e_d = 1'b0;
          CMD_CME: e_d = ~e_q;
          default: ;
        endcase
      end
    end
  end

  // NOTE: only plain registers live here, so every one of them gets an async reset value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q     <= '0;
      dr_q     <= '0;
      alu_op_q <= ALU_ADD;
      alu_e_q  <= 1'b0;
      ac_q     <= '0;
      e_q      <= 1'b0;
    end else begin
      op_q     <= op_d;
      dr_q     <= dr_d;
      alu_op_q <= alu_op_d;
      alu_e_q  <= alu_e_d;
      ac_q     <= ac_d;
      e_q      <= e_d;
    end
  end

  ac_flag_reg u_flag_reg (
    .clk      (clk),
    .rst_n    (rst_n),
    .alu_wr_i (flag_alu_wr),
    .cla_i    (flag_cla),
    .co_i     (alu_co),
    .ovf_i    (alu_ovf),
    .n_i      (alu_n),
    .z_i      (alu_z),
    .flags_o  (flags)
  );

  assign alu_ac = ac_q;
  assign alu_dr = dr_q;
  assign alu_op = alu_op_q;
  assign alu_e  = alu_e_q;
  assign ac     = ac_q;
  assign e      = e_q;

endmodule

// File: tb/tb_ac_exec_unit.sv
// Bench for ac_exec_unit with a behavioural ALU attached; expected results are
// queued at accept and compared by a monitor whenever done is presented.
module tb_ac_exec_unit;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [3:0]   cmd_op;
  logic [W-1:0] cmd_data;
  logic [W-1:0] alu_ac, alu_dr, alu_res;
  logic         alu_e;
  logic [2:0]   alu_op;
  logic         alu_co, alu_ovf, alu_n, alu_z;
  logic [W-1:0] ac;
  logic         e;
  logic [3:0]   flags;
  logic         done, cmd_err;

  ac_exec_unit #(.W(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_data(cmd_data),
    .alu_ac(alu_ac), .alu_dr(alu_dr), .alu_e(alu_e), .alu_op(alu_op),
    .alu_res(alu_res), .alu_co(alu_co), .alu_ovf(alu_ovf), .alu_n(alu_n), .alu_z(alu_z),
    .ac(ac), .e(e), .flags(flags), .done(done), .cmd_err(cmd_err)
  );

  always #5 clk = ~clk;

  // Reference ALU: shifts move by alu_e and report the bit shifted out as CO.
  always_comb begin
    logic [W:0] sum;
    sum     = {1'b0, alu_ac} + {1'b0, alu_dr};
    alu_res = '0;
    alu_co  = 1'b0;
    alu_ovf = 1'b0;
    case (alu_op)
      3'd0: begin
        alu_res = sum[W-1:0];
        alu_co  = sum[W];
        alu_ovf = (alu_ac[W-1] == alu_dr[W-1]) && (sum[W-1] != alu_ac[W-1]);
      end
      3'd1: alu_res = alu_ac & alu_dr;
      3'd2: alu_res = alu_dr;
      3'd3: alu_res = ~alu_ac;
      3'd4: begin
        alu_res = alu_e ? (alu_ac >> 1) : alu_ac;
        alu_co  = alu_e ? alu_ac[0] : 1'b0;
      end
      3'd5: begin
        alu_res = alu_e ? (alu_ac << 1) : alu_ac;
        alu_co  = alu_e ? alu_ac[W-1] : 1'b0;
      end
      default: alu_res = '0;
    endcase
    alu_n = alu_res[W-1];
    alu_z = (alu_res == '0);
  end

  typedef struct packed {
    logic [W-1:0] ac;
    logic         e;
    logic [3:0]   f;
    logic         err;
  } exp_t;

  exp_t sb_q[$];
  int   acc_q[$];
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  int   last_acc = 0;
  bit   have_acc = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: busy-ready check, plus scoreboard compare on every done pulse.
  always @(negedge clk) begin
    exp_t ex;
    int   a;
    if (!rst_n) begin
      acc_q.delete();
      have_acc = 0;
    end else begin
      if (have_acc && (cyc == last_acc + 1 || cyc == last_acc + 2))
        check("ready_low_busy", {31'd0, cmd_ready}, 32'd0);
      if (done) begin
        if (sb_q.size() == 0 || acc_q.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          ex = sb_q.pop_front();
          a  = acc_q.pop_front();
          check("latency", cyc - a, 32'd2);
          check("ac", {16'd0, ac}, {16'd0, ex.ac});
          check("e", {31'd0, e}, {31'd0, ex.e});
          check("flags", {28'd0, flags}, {28'd0, ex.f});
          check("cmd_err", {31'd0, cmd_err}, {31'd0, ex.err});
        end
      end
      if (cmd_valid && cmd_ready) begin
        acc_q.push_back(cyc);
        last_acc = cyc;
        have_acc = 1;
      end
    end
  end

  // Called one time unit after a rising edge; returns at the same point after accept.
  task automatic issue(input logic [3:0] op, input logic [W-1:0] data,
                       input logic [W-1:0] eac, input logic ee, input logic [3:0] ef,
                       input logic eerr, input bit hold, output int acc_cyc);
    bit ok = 0;
    exp_t ex;
    acc_cyc   = -1;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = data;
    for (int n = 0; n < 10 && !ok; n++) begin
      @(negedge clk);
      if (cmd_ready) begin
        ok      = 1;
        acc_cyc = cyc;
        ex      = '{ac: eac, e: ee, f: ef, err: eerr};
        sb_q.push_back(ex);
      end
      @(posedge clk);
      #1;
    end
    if (!ok) check("accept_timeout", 32'd0, 32'd1);
    if (!hold || !ok) cmd_valid = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [3:0] and_flags;
  int a0, a1, a2, ax;

  initial begin
`ifdef OVF_STICKY_EN
    and_flags = 4'b0110;
`else
    and_flags = 4'b0010;
`endif
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = '0;
    cmd_data  = '0;
    repeat (2) @(negedge clk);
    check("rst_ac", {16'd0, ac}, 32'd0);
    check("rst_flags", {28'd0, flags}, 32'd0);
    check("rst_alu_op", {29'd0, alu_op}, 32'd0);
    check("rst_alu_e", {31'd0, alu_e}, 32'd0);
    check("rst_ready", {31'd0, cmd_ready}, 32'd1);
    tick();
    rst_n = 1'b1;
    tick();

    // Reset in the middle of an ADD's EXEC cycle.
    issue(4'd2, 16'h8000, 16'h8000, 1'b0, 4'b0010, 1'b0, 0, ax);
    tick();
    tick();
    cmd_valid = 1'b1;
    cmd_op    = 4'd0;
    cmd_data  = 16'h8000;
    tick();
    cmd_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check("abort_ac", {16'd0, ac}, 32'd0);
    check("abort_e", {31'd0, e}, 32'd0);
    check("abort_flags", {28'd0, flags}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    tick();
    rst_n = 1'b1;
    check("abort_ready", {31'd0, cmd_ready}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("abort_no_done", {31'd0, done}, 32'd0);
    end
    tick();

    // LDA / INC overflow, then CLA.
    issue(4'd2, 16'h7FFF, 16'h7FFF, 1'b0, 4'b0000, 1'b0, 0, ax);
    issue(4'd6, 16'h1234, 16'h8000, 1'b0, 4'b0110, 1'b0, 0, ax);
    check("inc_dr_forced", {16'd0, alu_dr}, 32'd1);
    check("inc_alu_op", {29'd0, alu_op}, 32'd0);
    issue(4'd7, 16'h0000, 16'h0000, 1'b0, 4'b0001, 1'b0, 0, ax);

    // Wraparound ADD with carry and overflow.
    issue(4'd2, 16'h8000, 16'h8000, 1'b0, 4'b0010, 1'b0, 0, ax);
    issue(4'd0, 16'h8000, 16'h0000, 1'b1, 4'b1101, 1'b0, 0, ax);
    issue(4'd7, 16'h0000, 16'h0000, 1'b1, 4'b0001, 1'b0, 0, ax);

    // Shifts and E manipulation.
    issue(4'd2, 16'h8001, 16'h8001, 1'b1, 4'b0010, 1'b0, 0, ax);
    issue(4'd5, 16'h0000, 16'h0002, 1'b1, 4'b1000, 1'b0, 0, ax);
    check("cil_alu_e", {31'd0, alu_e}, 32'd1);
    issue(4'd4, 16'h0000, 16'h0001, 1'b0, 4'b0000, 1'b0, 0, ax);
    issue(4'd9, 16'h0000, 16'h0001, 1'b1, 4'b0000, 1'b0, 0, ax);
    issue(4'd8, 16'h0000, 16'h0001, 1'b0, 4'b0000, 1'b0, 0, ax);

    // Held cmd_valid: one accept every three cycles.
    issue(4'd0, 16'h0001, 16'h0002, 1'b0, 4'b0000, 1'b0, 1, a0);
    issue(4'd0, 16'h0001, 16'h0003, 1'b0, 4'b0000, 1'b0, 1, a1);
    issue(4'd0, 16'h0001, 16'h0004, 1'b0, 4'b0000, 1'b0, 0, a2);
    check("held_spacing_1", a1 - a0, 32'd3);
    check("held_spacing_2", a2 - a1, 32'd3);
    issue(4'hF, 16'hFFFF, 16'h0004, 1'b0, 4'b0000, 1'b1, 0, ax);
    issue(4'hA, 16'h5555, 16'h0004, 1'b0, 4'b0000, 1'b1, 0, ax);
    issue(4'd3, 16'h0000, 16'hFFFB, 1'b0, 4'b0010, 1'b0, 0, ax);

    // OVF behaviour across a following non-overflowing ALU op.
    issue(4'd2, 16'h7FFF, 16'h7FFF, 1'b0, 4'b0000, 1'b0, 0, ax);
    issue(4'd0, 16'h0001, 16'h8000, 1'b0, 4'b0110, 1'b0, 0, ax);
    issue(4'd1, 16'hFFFF, 16'h8000, 1'b0, and_flags, 1'b0, 0, ax);
    issue(4'd7, 16'h0000, 16'h0000, 1'b0, 4'b0001, 1'b0, 0, ax);

    for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(negedge clk);
    check("drain_pending", sb_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
